// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered toward the ALU; the result is captured and held until its owner takes it.
module alu_req_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPRN_WIDTH    = 6,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [OPRN_WIDTH-1:0] req0_oprn,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_err,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [OPRN_WIDTH-1:0] req1_oprn,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_err,

    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [OPRN_WIDTH-1:0] alu_oprn,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ptr;
    logic                  r_owner;
    logic [3:0]            r_cnt;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_alu_op1;
    logic [DATA_WIDTH-1:0] r_alu_op2;
    logic [OPRN_WIDTH-1:0] r_alu_oprn;
    logic [DATA_WIDTH-1:0] r_rsp0_result;
    logic [DATA_WIDTH-1:0] r_rsp1_result;

    logic                  w_grant;
    logic                  w_req0_ready;
    logic                  w_req1_ready;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_rsp_fire;
    logic [DATA_WIDTH-1:0] w_win_op1;
    logic [DATA_WIDTH-1:0] w_win_op2;
    logic [OPRN_WIDTH-1:0] w_win_oprn;
    logic                  w_win_err;

    // Grant: a lone requester wins outright; on contention the pointer decides.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = r_ptr;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
        w_req0_ready = (r_state == ST_IDLE) && !w_grant && req0_valid;
        w_req1_ready = (r_state == ST_IDLE) &&  w_grant && req1_valid;
        w_accept     = w_req0_ready || w_req1_ready;

        w_win_op1  = w_grant ? req1_op1  : req0_op1;
        w_win_op2  = w_grant ? req1_op2  : req0_op2;
        w_win_oprn = w_grant ? req1_oprn : req0_oprn;
        w_win_err  = (w_win_oprn == '0) || (w_win_oprn > OPRN_WIDTH'(9));

        w_capture  = (r_state == ST_SETTLE) && (r_cnt == '0);
        w_rsp_fire = (r_state == ST_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)   w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_capture)  w_state_nxt = ST_RESP;
            ST_RESP:   if (w_rsp_fire) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 1'b0;
            r_owner       <= 1'b0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            r_alu_op1     <= '0;
            r_alu_op2     <= '0;
            r_alu_oprn    <= '0;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_alu_op1  <= w_win_op1;
                r_alu_op2  <= w_win_op2;
                r_alu_oprn <= w_win_oprn;
                r_owner    <= w_grant;
                r_cnt      <= 4'(SETTLE_CYCLES - 1);
                r_err      <= w_win_err;
            end else if ((r_state == ST_SETTLE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Only the owner's result register is loaded; the other port reads 0 from then on.
            if (w_capture) begin
                if (r_owner) begin
                    r_rsp1_result <= r_err ? '0 : alu_result;
                    r_rsp0_result <= '0;
                end else begin
                    r_rsp0_result <= r_err ? '0 : alu_result;
                    r_rsp1_result <= '0;
                end
            end

            if (w_rsp_fire) begin
                r_ptr <= ~r_owner;
            end
        end
    end

    always_comb begin
        req0_ready  = w_req0_ready;
        req1_ready  = w_req1_ready;
        rsp0_valid  = (r_state == ST_RESP) && !r_owner;
        rsp1_valid  = (r_state == ST_RESP) &&  r_owner;
        rsp0_err    = rsp0_valid && r_err;
        rsp1_err    = rsp1_valid && r_err;
        rsp0_result = r_rsp0_result;
        rsp1_result = r_rsp1_result;
        alu_op1     = r_alu_op1;
        alu_op2     = r_alu_op2;
        alu_oprn    = r_alu_oprn;
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: a behavioural ALU closes the loop, expected
// responses are queued at each accept and compared when the owner takes its result.
module tb_alu_req_arbiter;

    localparam int DW = 32;
    localparam int OW = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // DUT A (SETTLE_CYCLES = 1)
    logic          req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [DW-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [OW-1:0] req0_oprn = '0, req1_oprn = '0;
    logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic          rsp0_ready = 1, rsp1_ready = 1;
    logic [DW-1:0] rsp0_result, rsp1_result, alu_op1, alu_op2, alu_result;
    logic [OW-1:0] alu_oprn;

    // DUT B (SETTLE_CYCLES = 3)
    logic          b_req0_valid = 0, b_req0_ready, b_req1_ready;
    logic [DW-1:0] b_req0_op1 = '0, b_req0_op2 = '0;
    logic [OW-1:0] b_req0_oprn = '0;
    logic          b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err;
    logic          b_rsp0_ready = 1;
    logic [DW-1:0] b_rsp0_result, b_rsp1_result, b_alu_op1, b_alu_op2, b_alu_result;
    logic [OW-1:0] b_alu_oprn;

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, b, input logic [OW-1:0] op);
        case (op)
            6'h01:   return a + b;
            6'h02:   return a - b;
            6'h03:   return a * b;
            6'h04:   return a >> b;
            6'h05:   return a << b;
            6'h06:   return a & b;
            6'h07:   return a | b;
            6'h08:   return ~(a | b);
            6'h09:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    always_comb alu_result   = alu_fn(alu_op1, alu_op2, alu_oprn);
    always_comb b_alu_result = alu_fn(b_alu_op1, b_alu_op2, b_alu_oprn);

    alu_req_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .SETTLE_CYCLES(1)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
        .req0_op2(req0_op2), .req0_oprn(req0_oprn),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
        .req1_op2(req1_op2), .req1_oprn(req1_oprn),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprn(alu_oprn), .alu_result(alu_result)
    );

    alu_req_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .SETTLE_CYCLES(3)) dut_b (
        .CLK(CLK), .RST(RST),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op1(b_req0_op1),
        .req0_op2(b_req0_op2), .req0_oprn(b_req0_oprn),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_result(b_rsp0_result), .rsp0_err(b_rsp0_err),
        .req1_valid(1'b0), .req1_ready(b_req1_ready), .req1_op1('0),
        .req1_op2('0), .req1_oprn('0),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(1'b1), .rsp1_result(b_rsp1_result), .rsp1_err(b_rsp1_err),
        .alu_op1(b_alu_op1), .alu_op2(b_alu_op2), .alu_oprn(b_alu_oprn), .alu_result(b_alu_result)
    );

    typedef struct {
        logic [DW-1:0] res;
        logic          err;
        int unsigned   rise;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   acc_log[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Response monitor: latency checked on the rising edge of valid, data on the taking cycle.
    logic prev0 = 0, prev1 = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            prev0 = 0;
            prev1 = 0;
        end else begin
            if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 1, 0);
            if (rsp0_valid && !prev0) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
                else chk("rsp0_latency", cyc, q0[0].rise);
            end
            if (rsp0_valid && rsp0_ready && q0.size() != 0) begin
                e = q0.pop_front();
                chk("rsp0_result", rsp0_result, e.res);
                chk("rsp0_err", {31'd0, rsp0_err}, {31'd0, e.err});
            end
            if (rsp1_valid && !prev1) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
                else chk("rsp1_latency", cyc, q1[0].rise);
            end
            if (rsp1_valid && rsp1_ready && q1.size() != 0) begin
                e = q1.pop_front();
                chk("rsp1_result", rsp1_result, e.res);
                chk("rsp1_err", {31'd0, rsp1_err}, {31'd0, e.err});
            end
            prev0 = rsp0_valid;
            prev1 = rsp1_valid;
        end
    end

    task automatic issue(input int n, input logic [DW-1:0] a, b, input logic [OW-1:0] op,
                         input logic [DW-1:0] er, input logic ee);
        bit   ok = 0;
        exp_t e;
        if (n == 0) begin
            req0_op1 = a; req0_op2 = b; req0_oprn = op; req0_valid = 1;
        end else begin
            req1_op1 = a; req1_op2 = b; req1_oprn = op; req1_valid = 1;
        end
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge CLK);
            if ((n == 0) ? req0_ready : req1_ready) ok = 1;
        end
        if (ok) begin
            e.res  = er;
            e.err  = ee;
            e.rise = cyc + 2;
            if (n == 0) q0.push_back(e);
            else q1.push_back(e);
            acc_log.push_back(n);
        end else begin
            chk($sformatf("req%0d_accept_timeout", n), 0, 1);
        end
        @(posedge CLK);
        #1;
        if (n == 0) req0_valid = 0;
        else req1_valid = 0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge CLK);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        RST = 0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1;
    endtask

    initial begin
        int unsigned c;
        bit          ok;

        #1 RST = 0;
        #2;
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
        chk("rst_rsp1_result", rsp1_result, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_oprn", {26'd0, alu_oprn}, 0);
        @(posedge CLK);
        #1 RST = 1;

        // 1: single add on requester 0
        issue(0, 15, 3, 6'h01, 18, 0);
        drain();
        chk("t1_hold_result", rsp0_result, 18);
        chk("t1_valid_low", {31'd0, rsp0_valid}, 0);

        // 2: contention after reset goes to requester 0 first
        do_reset();
        acc_log.delete();
        fork
            issue(0, 15, 5, 6'h02, 10, 0);
            issue(1, 2, 7, 6'h03, 14, 0);
        join
        drain();
        chk("t2_acc_count", acc_log.size(), 2);
        chk("t2_first", acc_log[0], 0);
        chk("t2_second", acc_log[1], 1);

        // pointer moves to 1 after requester 0 completes
        issue(0, 1, 1, 6'h01, 2, 0);
        drain();
        acc_log.delete();
        fork
            issue(0, 6, 2, 6'h02, 4, 0);
            issue(1, 6, 3, 6'h07, 7, 0);
        join
        drain();
        chk("alt_first", acc_log[0], 1);
        chk("alt_second", acc_log[1], 0);

        // 3: backpressure on requester 1 while requester 0 waits
        rsp1_ready = 0;
        issue(1, 2, 7, 6'h03, 14, 0);
        for (int i = 0; i < 20 && !rsp1_valid; i++) @(negedge CLK);
        chk("t3_valid_seen", {31'd0, rsp1_valid}, 1);
        fork
            issue(0, 9, 4, 6'h02, 5, 0);
        join_none
        repeat (5) begin
            @(negedge CLK);
            chk("t3_hold_valid", {31'd0, rsp1_valid}, 1);
            chk("t3_hold_result", rsp1_result, 14);
            chk("t3_req0_ready", {31'd0, req0_ready}, 0);
        end
        @(posedge CLK);
        #1 rsp1_ready = 1;
        drain();

        // 4: illegal opcodes report err with zero result; NOR result left on port 1
        issue(1, 1, 0, 6'h0A, 0, 1);
        drain();
        issue(0, 5, 5, 6'h00, 0, 1);
        drain();
        issue(1, 1, 0, 6'h08, 32'hFFFFFFFE, 0);
        drain();

        // 6: reset during SETTLE drops the operation
        issue(0, 7, 7, 6'h01, 14, 0);
        #1 RST = 0;
        q0.delete();
        #1;
        chk("t6_rsp0_valid", {31'd0, rsp0_valid}, 0);
        chk("t6_rsp1_result", rsp1_result, 0);
        chk("t6_alu_op1", alu_op1, 0);
        chk("t6_alu_op2", alu_op2, 0);
        chk("t6_alu_oprn", {26'd0, alu_oprn}, 0);
        repeat (2) begin
            @(negedge CLK);
            chk("t6_no_rsp", {31'd0, rsp0_valid}, 0);
        end
        @(posedge CLK);
        #1 RST = 1;
        issue(0, 4, 5, 6'h09, 1, 0);
        drain();

        // 5: SETTLE_CYCLES = 3 instance, shift left
        b_req0_op1 = 3; b_req0_op2 = 3; b_req0_oprn = 6'h05; b_req0_valid = 1;
        ok = 0;
        c  = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            if (b_req0_ready) begin
                ok = 1;
                c  = cyc;
            end
        end
        chk("t5_accept", {31'd0, ok}, 1);
        @(posedge CLK);
        #1;
        b_req0_valid = 0;
        b_req0_op1   = 99;
        b_req0_oprn  = 6'h01;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            chk("t5_settle_valid", {31'd0, b_rsp0_valid}, 0);
            chk("t5_alu_op1", b_alu_op1, 3);
            chk("t5_alu_op2", b_alu_op2, 3);
            chk("t5_alu_oprn", {26'd0, b_alu_oprn}, 5);
        end
        @(negedge CLK);
        chk("t5_rise", {31'd0, b_rsp0_valid}, 1);
        chk("t5_rise_cycle", cyc, c + 4);
        chk("t5_result", b_rsp0_result, 24);
        @(negedge CLK);
        chk("t5_done_valid", {31'd0, b_rsp0_valid}, 0);
        chk("t5_hold_result", b_rsp0_result, 24);
        chk("t5_hold_alu", b_alu_op1, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
